// File: rtl/inj_pkg.sv
// Shared types and defaults for the injection scheduler and the per-node
// dataout buffers it sequences.
package inj_pkg;

  localparam int DEF_NUM_NODES      = 16;
  localparam int DEF_WORDS_PER_NODE = 30;

  localparam logic MODE_SEQ = 1'b0;
  localparam logic MODE_PAR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_SEQ = 3'd1,
    ST_GAP     = 3'd2,
    ST_RUN_PAR = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } inj_state_e;

  function automatic logic is_busy(input inj_state_e s);
    return (s == ST_RUN_SEQ) || (s == ST_GAP) || (s == ST_RUN_PAR);
  endfunction

endpackage

// File: rtl/inj_word_ctr.sv
// Per-node accepted-word counter; saturates at WORDS and flags completion.
module inj_word_ctr
  import inj_pkg::*;
#(
  parameter int WORDS = DEF_WORDS_PER_NODE
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  output logic last_o,
  output logic complete_o
);

  localparam int CNT_W = $clog2(WORDS + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != CNT_W'(WORDS))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // last_o lets the controller retire a node on the same edge as its final word.
  assign last_o     = (count_q == CNT_W'(WORDS - 1));
  assign complete_o = (count_q == CNT_W'(WORDS));

endmodule

// File: rtl/inj_sched.sv
// Injection scheduler: enables the per-node ROM buffers one at a time or all
// together, counts their valid words and reports done / error.
module inj_sched
  import inj_pkg::*;
#(
  parameter int NUM_NODES      = DEF_NUM_NODES,
  parameter int WORDS_PER_NODE = DEF_WORDS_PER_NODE,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT        = 64,
  localparam int CW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
  localparam int TW = $clog2(NUM_NODES * WORDS_PER_NODE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic                 stall_i,
  input  logic [NUM_NODES-1:0] node_valid_i,
  output logic [NUM_NODES-1:0] node_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CW-1:0]        cur_node_o,
  output logic [TW-1:0]        total_words_o,
  output inj_state_e           state_o
);

  localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TOW = $clog2(TIMEOUT + 1);

  inj_state_e           state_q, state_d;
  logic [NUM_NODES-1:0] en_q, en_d, en_prev_q;
  logic [CW-1:0]        cur_node_q, cur_node_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [TOW-1:0]       tmo_q, tmo_d;
  logic [TW-1:0]        total_q, total_d;
  logic                 done_q, done_d, err_q, err_d, busy_q;

  logic [NUM_NODES-1:0] accept, inc, last, complete, fin;
  logic                 proto_err, timeout_hit, running, any_valid;
  logic [CW:0]          pop;
  logic [TW:0]          sum;

  // Stall gating is the only combinational path to the buffers.
  assign node_en_o = en_q & {NUM_NODES{~stall_i}};

  // A node may deliver a word while enabled or in the cycle after its enable dropped.
  assign accept    = (en_q | en_prev_q) & ~complete;
  assign inc       = node_valid_i & accept;
  assign proto_err = |(node_valid_i & ~accept);
  assign fin       = complete | (inc & last);
  assign any_valid = |node_valid_i;

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_ctr
    inj_word_ctr #(.WORDS(WORDS_PER_NODE)) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (inc[g]),
      .last_o    (last[g]),
      .complete_o(complete[g])
    );
  end

  // The watchdog only runs while buffers are meant to be enabled; a gap is deliberate silence.
  assign running     = (state_q == ST_RUN_SEQ) || (state_q == ST_RUN_PAR);
  assign tmo_d       = (!running || any_valid || stall_i) ? '0 : tmo_q + TOW'(1);
  assign timeout_hit = running && !any_valid && !stall_i && (tmo_q == TOW'(TIMEOUT - 1));

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      pop = pop + (CW + 1)'(inc[i]);
    end
    sum     = {1'b0, total_q} + (TW + 1)'(pop);
    total_d = sum[TW] ? '1 : sum[TW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    cur_node_d = cur_node_q;
    gap_d      = gap_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (mode_i == MODE_PAR) begin
            state_d = ST_RUN_PAR;
            en_d    = '1;
          end else begin
            state_d    = ST_RUN_SEQ;
            cur_node_d = '0;
            en_d       = NUM_NODES'(1);
          end
        end
      end
      ST_RUN_SEQ: begin
        if (proto_err) begin
          state_d = ST_ERR;
        end else if (fin[cur_node_q]) begin
          en_d = '0;
          if (cur_node_q == CW'(NUM_NODES - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            cur_node_d = cur_node_q + CW'(1);
            en_d       = NUM_NODES'(1) << (cur_node_q + CW'(1));
          end
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_GAP: begin
        if (proto_err) begin
          state_d = ST_ERR;
        end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d    = ST_RUN_SEQ;
          cur_node_d = cur_node_q + CW'(1);
          en_d       = NUM_NODES'(1) << (cur_node_q + CW'(1));
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_RUN_PAR: begin
        if (proto_err) begin
          state_d = ST_ERR;
        end else if (&fin) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          en_d    = '0;
        end else begin
          en_d = en_q & ~fin;
          if (timeout_hit) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DONE: en_d = '0;
      ST_ERR:  en_d = '0;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_ERR) begin
      en_d  = '0;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      en_q       <= '0;
      en_prev_q  <= '0;
      cur_node_q <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      total_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      en_prev_q  <= node_en_o;
      cur_node_q <= cur_node_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      total_q    <= total_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= is_busy(state_d);
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign cur_node_o    = cur_node_q;
  assign total_words_o = total_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_inj_sched.sv
// Bench for inj_sched: behavioural ROM buffers (2-cycle startup, 1-cycle lag,
// 30-word depth) driven by the scheduler's enables.
module tb_inj_sched;
  import inj_pkg::*;

  localparam int N   = 16;
  localparam int W   = 30;
  localparam int GAP = 4;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic          stall_i = 1'b0;
  logic [N-1:0]  node_valid, node_en, buf_vld, primed;
  logic [N-1:0]  dead_mask = '0;
  logic [N-1:0]  spur = '0;
  logic          busy, done, err;
  logic [3:0]    cur_node;
  logic [8:0]    total_words;
  inj_state_e    state;
  int            rem [N];

  int            n_total = 0;
  int            n_bad = 0;
  int            cyc_n = 0;
  int            vcount [N];
  int            last_vld [N];
  int            rise_cyc [N];
  logic [N-1:0]  seen, drop_pend;
  bit            mon_seq;
  logic [3:0]    exp_q [$];

  always #5 clk = ~clk;

  assign node_valid = (buf_vld & ~dead_mask) | spur;

  inj_sched #(
    .NUM_NODES(N), .WORDS_PER_NODE(W), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .stall_i      (stall_i),
    .node_valid_i (node_valid),
    .node_en_o    (node_en),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .cur_node_o   (cur_node),
    .total_words_o(total_words),
    .state_o      (state)
  );

  // Buffer model: first enabled cycle primes the ROM, later enabled cycles emit a word next cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld <= '0;
      primed  <= '0;
      for (int i = 0; i < N; i++) rem[i] <= W;
    end else begin
      for (int i = 0; i < N; i++) begin
        primed[i] <= primed[i] | node_en[i];
        if (node_en[i] && primed[i] && rem[i] != 0) begin
          buf_vld[i] <= 1'b1;
          rem[i]     <= rem[i] - 1;
        end else begin
          buf_vld[i] <= 1'b0;
        end
      end
    end
  end

  task automatic clear_track();
    for (int i = 0; i < N; i++) begin
      vcount[i] = 0; last_vld[i] = 0; rise_cyc[i] = 0;
    end
    seen = '0; drop_pend = '0; mon_seq = 1'b0;
    exp_q.delete();
  endtask

  // One cycle: sample at the falling edge, track words and enable edges, check scoreboard.
  task automatic tick();
    logic [3:0] e;
    @(negedge clk);
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      if (drop_pend[i]) begin
        drop_pend[i] = 1'b0;
        n_total++;
        if (node_en[i] !== 1'b0) begin
          n_bad++; $display("FAIL en_drop node %0d: node_en=%b want 0 after word %0d", i, node_en[i], W);
        end
      end
      if (node_valid[i] === 1'b1) begin
        vcount[i]++; last_vld[i] = cyc_n;
        if (vcount[i] == W) drop_pend[i] = 1'b1;
      end
      if (node_en[i] === 1'b1 && !seen[i]) begin
        seen[i] = 1'b1; rise_cyc[i] = cyc_n;
        if (mon_seq) begin
          n_total++;
          if (exp_q.size() == 0) begin
            n_bad++; $display("FAIL seq_order: node %0d enabled, none expected", i);
          end else begin
            e = exp_q.pop_front();
            if (4'(i) !== e) begin
              n_bad++; $display("FAIL seq_order: node %0d enabled, want %0d", i, e);
            end
          end
          n_total++;
          if (cur_node !== 4'(i)) begin
            n_bad++; $display("FAIL cur_node: got %0d want %0d", cur_node, i);
          end
          if (i > 0) begin
            n_total++;
            if (rise_cyc[i] - last_vld[i-1] != GAP + 1) begin
              n_bad++; $display("FAIL gap node %0d: %0d cycles after last word, want %0d", i, rise_cyc[i] - last_vld[i-1], GAP + 1);
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start_i = 1'b0; stall_i = 1'b0; spur = '0; dead_mask = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_track();
  endtask

  task automatic start_pulse(input logic m);
    start_i = 1'b1; mode_i = m;
    tick();
    start_i = 1'b0;
  endtask

  task automatic push_all();
    for (int i = 0; i < N; i++) exp_q.push_back(4'(i));
    mon_seq = 1'b1;
  endtask

  task automatic wait_end(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done === 1'b1 || err === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_total++;
    if (!ok) begin
      n_bad++; $display("FAIL wait_end: no done/err within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (node_en !== '0) begin n_bad++; $display("FAIL rst_en: got %h want 0", node_en); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_total++; if (cur_node !== 4'd0) begin n_bad++; $display("FAIL rst_cur: got %0d want 0", cur_node); end
    n_total++; if (total_words !== 9'd0) begin n_bad++; $display("FAIL rst_total: got %0d want 0", total_words); end
    n_total++; if (state !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want IDLE", state); end
  endtask

  task automatic test_sequential();
    do_reset();
    push_all();
    start_pulse(MODE_SEQ);
    n_total++; if (node_en !== 16'h0001) begin n_bad++; $display("FAIL seq_en_c1: got %h want 0001", node_en); end
    n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL seq_busy: got %b want 1", busy); end
    tick();
    n_total++; if (node_valid[0] !== 1'b0) begin n_bad++; $display("FAIL seq_vld_c2: got %b want 0", node_valid[0]); end
    tick();
    n_total++; if (node_valid[0] !== 1'b1) begin n_bad++; $display("FAIL seq_vld_c3: got %b want 1", node_valid[0]); end
    wait_end(1500);
    n_total++; if (done !== 1'b1) begin n_bad++; $display("FAIL seq_done: got %b want 1", done); end
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL seq_err: got %b want 0", err); end
    n_total++; if (total_words !== 9'd480) begin n_bad++; $display("FAIL seq_total: got %0d want 480", total_words); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL seq_busy_end: got %b want 0", busy); end
    n_total++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL seq_left: %0d nodes never enabled", exp_q.size()); end
    start_pulse(MODE_PAR);
    tick();
    n_total++; if (state !== ST_DONE) begin n_bad++; $display("FAIL done_start: state %0d want DONE", state); end
    n_total++; if (node_en !== '0) begin n_bad++; $display("FAIL done_start_en: got %h want 0", node_en); end
  endtask

  task automatic test_parallel();
    int s;
    do_reset();
    start_pulse(MODE_PAR);
    s = cyc_n;
    n_total++; if (node_en !== 16'hFFFF) begin n_bad++; $display("FAIL par_en: got %h want ffff", node_en); end
    wait_end(200);
    n_total++; if (cyc_n - s != 32) begin n_bad++; $display("FAIL par_latency: done %0d cycles after enable, want 32", cyc_n - s); end
    n_total++; if (done !== 1'b1) begin n_bad++; $display("FAIL par_done: got %b want 1", done); end
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL par_err: got %b want 0", err); end
    n_total++; if (total_words !== 9'd480) begin n_bad++; $display("FAIL par_total: got %0d want 480", total_words); end
    n_total++; if (node_en !== '0) begin n_bad++; $display("FAIL par_en_end: got %h want 0", node_en); end
  endtask

  task automatic test_stall();
    int k;
    do_reset();
    push_all();
    start_pulse(MODE_SEQ);
    k = 0;
    while (vcount[3] < 10 && k < 1000) begin tick(); k++; end
    n_total++; if (vcount[3] < 10) begin n_bad++; $display("FAIL stall_reach: node 3 words %0d want >=10", vcount[3]); end
    stall_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_total++; if (node_en !== '0) begin n_bad++; $display("FAIL stall_en cycle %0d: got %h want 0", c, node_en); end
    end
    stall_i = 1'b0;
    wait_end(1500);
    n_total++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL stall_end: done=%b err=%b want 1/0", done, err); end
    n_total++; if (vcount[3] != W) begin n_bad++; $display("FAIL stall_words: node 3 gave %0d want %0d", vcount[3], W); end
    n_total++; if (total_words !== 9'd480) begin n_bad++; $display("FAIL stall_total: got %0d want 480", total_words); end
  endtask

  task automatic test_dead_buffer();
    do_reset();
    dead_mask = 16'h0020;
    push_all();
    start_pulse(MODE_SEQ);
    wait_end(1000);
    n_total++; if (err !== 1'b1) begin n_bad++; $display("FAIL dead_err: got %b want 1", err); end
    n_total++; if (cyc_n - rise_cyc[5] != TMO) begin n_bad++; $display("FAIL dead_latency: err %0d cycles after node 5 enable, want %0d", cyc_n - rise_cyc[5], TMO); end
    n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL dead_done: got %b want 0", done); end
    n_total++; if (node_en !== '0) begin n_bad++; $display("FAIL dead_en: got %h want 0", node_en); end
    n_total++; if (state !== ST_ERR) begin n_bad++; $display("FAIL dead_state: got %0d want ERR", state); end
    n_total++; if (total_words !== 9'd150) begin n_bad++; $display("FAIL dead_total: got %0d want 150", total_words); end
  endtask

  task automatic test_spurious();
    int k;
    do_reset();
    start_pulse(MODE_SEQ);
    k = 0;
    while (!(cur_node == 4'd2 && vcount[2] >= 5) && k < 1000) begin tick(); k++; end
    n_total++; if (vcount[2] < 5) begin n_bad++; $display("FAIL spur_reach: node 2 words %0d want >=5", vcount[2]); end
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL spur_pre_err: got %b want 0", err); end
    spur = 16'h0200;
    tick();
    spur = '0;
    n_total++; if (err !== 1'b1) begin n_bad++; $display("FAIL spur_err: got %b want 1", err); end
    n_total++; if (state !== ST_ERR) begin n_bad++; $display("FAIL spur_state: got %0d want ERR", state); end
    n_total++; if (node_en !== '0) begin n_bad++; $display("FAIL spur_en: got %h want 0", node_en); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL spur_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start_pulse(MODE_PAR);
    for (int c = 0; c < 10; c++) tick();
    #2 rst = 1'b1;
    #1;
    n_total++; if (node_en !== '0) begin n_bad++; $display("FAIL arst_en: got %h want 0", node_en); end
    n_total++; if (state !== ST_IDLE) begin n_bad++; $display("FAIL arst_state: got %0d want IDLE", state); end
    @(negedge clk);
    rst = 1'b0;
    clear_track();
    n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL arst_done: got %b want 0", done); end
    n_total++; if (total_words !== 9'd0) begin n_bad++; $display("FAIL arst_total: got %0d want 0", total_words); end
    start_pulse(MODE_PAR);
    n_total++; if (node_en !== 16'hFFFF) begin n_bad++; $display("FAIL arst_restart: got %h want ffff", node_en); end
    wait_end(200);
    n_total++; if (done !== 1'b1 || total_words !== 9'd480) begin n_bad++; $display("FAIL arst_rerun: done=%b total=%0d want 1/480", done, total_words); end
  endtask

  initial begin
    clear_track();
    test_reset();
    test_sequential();
    test_parallel();
    test_stall();
    test_dead_buffer();
    test_spurious();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
